// File: rtl/vram_write_buffer.sv
// Write FIFO between the rasterizer VRAM port and a sel/ack VRAM controller, with deferred front/back swap.
// Optional: define VRAM_WB_STATS_EN to add write_count_o (acknowledged-transaction counter).
module vram_write_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              wr_sel_i,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_mask_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              swap_req_i,
  output logic              wr_stall_o,
  output logic              mem_sel_o,
  output logic              mem_wr_o,
  output logic [3:0]        mem_mask_o,
  output logic [ADDR_W:0]   mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  output logic              front_buf_o,
  output logic              swap_done_o,
  output logic              overflow_o
`ifdef VRAM_WB_STATS_EN
  ,
  output logic [15:0]       write_count_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 1 + ADDR_W + 4 + DATA_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             swap_pending;
  logic             push, pop, issue, flip, fifo_empty;

  assign fifo_empty = (count == '0);
  assign wr_stall_o = (count == (PTR_W+1)'(DEPTH)) | swap_pending;
  assign push       = wr_sel_i & wr_en_i & ~wr_stall_o;
  assign flip       = swap_pending & fifo_empty & (state == IDLE);
  assign mem_wr_o   = mem_sel_o;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        issue      = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (mem_ack_i) begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Entries are tagged with the back bank at push time, so a later flip cannot retag them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {~front_buf_o, wr_addr_i, wr_mask_i, wr_data_i};
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_sel_o  <= 1'b0;
      mem_mask_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (issue) begin
      mem_sel_o <= 1'b1;
      {mem_addr_o, mem_mask_o, mem_data_o} <= fifo_mem[rd_ptr];
    end else if (pop) begin
      mem_sel_o <= 1'b0;
    end
  end

  // A request arriving on the flip cycle is merged into the flip in progress.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      swap_pending <= 1'b0;
      front_buf_o  <= 1'b0;
      swap_done_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      swap_done_o <= flip;
      if (flip) begin
        swap_pending <= 1'b0;
        front_buf_o  <= ~front_buf_o;
      end else if (swap_req_i) begin
        swap_pending <= 1'b1;
      end
      if (wr_sel_i & wr_en_i & wr_stall_o) overflow_o <= 1'b1;
    end
  end

`ifdef VRAM_WB_STATS_EN
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) write_count_o <= '0;
    else if (pop)   write_count_o <= write_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vram_write_buffer.sv
// Scoreboard bench for vram_write_buffer: stimulus queues expected VRAM transactions, a monitor checks each acked one.
module tb_vram_write_buffer;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        wr_sel_i = 1'b0, wr_en_i = 1'b0, swap_req_i = 1'b0;
  logic [3:0]  wr_mask_i = '0;
  logic [15:0] wr_addr_i = '0, wr_data_i = '0;
  logic        wr_stall_o, mem_sel_o, mem_wr_o, mem_ack_i;
  logic [3:0]  mem_mask_o;
  logic [16:0] mem_addr_o;
  logic [15:0] mem_data_o;
  logic        front_buf_o, swap_done_o, overflow_o;
`ifdef VRAM_WB_STATS_EN
  logic [15:0] write_count_o;
`endif

  vram_write_buffer #(.DEPTH(16), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .wr_sel_i(wr_sel_i), .wr_en_i(wr_en_i), .wr_mask_i(wr_mask_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .swap_req_i(swap_req_i),
    .wr_stall_o(wr_stall_o), .mem_sel_o(mem_sel_o), .mem_wr_o(mem_wr_o),
    .mem_mask_o(mem_mask_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .front_buf_o(front_buf_o), .swap_done_o(swap_done_o),
    .overflow_o(overflow_o)
`ifdef VRAM_WB_STATS_EN
    , .write_count_o(write_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  bit   model_front = 1'b0;
  bit   ack_force = 1'b0, ack_enable = 1'b0;
  int   ack_wait = 0;
  int   sel_cycles = 0, last_len = 0, pops_total = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit do_wr, input bit swap, input logic [3:0] mask,
                               input logic [15:0] addr, input logic [15:0] data, input bit accept);
    @(negedge clk);
    wr_sel_i = do_wr; wr_en_i = do_wr; swap_req_i = swap;
    wr_mask_i = mask; wr_addr_i = addr; wr_data_i = data;
    if (do_wr && accept) exp_q.push_back({~model_front, addr, mask, data});
    @(posedge clk); #1;
    wr_sel_i = 1'b0; wr_en_i = 1'b0; swap_req_i = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mem_sel_o) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, (exp_q.size() == 0 && !mem_sel_o), 1);
  endtask

  // Controller model plus monitor: drives ack, checks field stability and scoreboard order.
  initial begin
    logic [36:0] held;
    logic [36:0] exp;
    bit prev_sel;
    prev_sel = 1'b0;
    held = '0;
    mem_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        sel_cycles = 0; prev_sel = 1'b0; mem_ack_i = 1'b0;
        continue;
      end
      if (mem_sel_o) sel_cycles++; else sel_cycles = 0;
      if (ack_force) mem_ack_i = 1'b1;
      else mem_ack_i = ack_enable && mem_sel_o && (sel_cycles > ack_wait);
      if (mem_sel_o && !prev_sel) held = {mem_addr_o, mem_mask_o, mem_data_o};
      else if (mem_sel_o) checkOutput("hold_fields", {mem_addr_o, mem_mask_o, mem_data_o}, held);
      if (mem_sel_o) checkOutput("mem_wr_eq_sel", mem_wr_o, 1);
      if (mem_sel_o && mem_ack_i) begin
        last_len = sel_cycles;
        pops_total++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_txn: got %0h expected none", {mem_addr_o, mem_mask_o, mem_data_o});
        end else begin
          exp = exp_q.pop_front();
          checkOutput("txn", {mem_addr_o, mem_mask_o, mem_data_o}, exp);
        end
      end
      prev_sel = mem_sel_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses, pop_mark, pop_delta, n;
    bit stall_held;

    // Reset values
    #12;
    checkOutput("rst_sel", mem_sel_o, 0);
    checkOutput("rst_stall", wr_stall_o, 0);
    checkOutput("rst_front", front_buf_o, 0);
    checkOutput("rst_overflow", overflow_o, 0);
    checkOutput("rst_swap_done", swap_done_o, 0);
    checkOutput("rst_fields", {mem_addr_o, mem_mask_o, mem_data_o}, 0);
    @(negedge clk); reset_n_i = 1'b1;

    // sel without en must be ignored
    @(negedge clk); wr_sel_i = 1'b1; wr_en_i = 1'b0;
    @(posedge clk); #1; wr_sel_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkOutput("sel_no_en", mem_sel_o, 0);

    // Single write, ack held high
    ack_force = 1'b1;
    applyStimulus(1, 0, 4'hF, 16'h0010, 16'hABCD, 1);
    checkOutput("t1_sel_push_cycle", mem_sel_o, 0);
    @(posedge clk); #1;
    checkOutput("t1_sel_rise", mem_sel_o, 1);
    checkOutput("t1_addr", mem_addr_o, 17'h10010);
    checkOutput("t1_data", mem_data_o, 16'hABCD);
    @(posedge clk); #1;
    checkOutput("t1_sel_fall", mem_sel_o, 0);
    ack_force = 1'b0;
    waitDrain("t1_drain", 20);

    // Fill to full with ack held low, then overflow
    ack_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 4'(i), 16'(i), 16'h1000 + 16'(i), 1);
      if (i == 14) checkOutput("t2_stall_at15", wr_stall_o, 0);
    end
    checkOutput("t2_stall_full", wr_stall_o, 1);
    checkOutput("t2_no_overflow_yet", overflow_o, 0);
    applyStimulus(1, 0, 4'h5, 16'h00AA, 16'hDEAD, 0);
    checkOutput("t2_overflow", overflow_o, 1);
    ack_enable = 1'b1; ack_wait = 0;
    waitDrain("t2_drain", 100);
    checkOutput("t2_stall_release", wr_stall_o, 0);
    checkOutput("t2_overflow_sticky", overflow_o, 1);

    // Delayed ack: six sel cycles, one pop
    ack_wait = 5;
    applyStimulus(1, 0, 4'h3, 16'h0033, 16'h3333, 1);
    waitDrain("t3_drain", 30);
    checkOutput("t3_sel_len", last_len, 6);
    repeat (2) @(posedge clk);
    #1 checkOutput("t3_single_pop", mem_sel_o, 0);
    ack_wait = 0;

    // Three writes then swap; a write during pending is dropped
    ack_enable = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 4'hC, 16'h0020 + 16'(i), 16'h2000 + 16'(i), 1);
    applyStimulus(0, 1, 4'h0, 16'h0, 16'h0, 0);
    checkOutput("t4_stall_pending", wr_stall_o, 1);
    applyStimulus(1, 0, 4'h1, 16'h0099, 16'h9999, 0);
    pop_mark = pops_total;
    ack_enable = 1'b1;
    stall_held = 1'b1;
    n = 0;
    while (!swap_done_o && n < 60) begin
      if (!wr_stall_o) stall_held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t4_stall_held", stall_held, 1);
    checkOutput("t4_swap_done", swap_done_o, 1);
    checkOutput("t4_pops_before_flip", pops_total - pop_mark, 3);
    checkOutput("t4_front", front_buf_o, 1);
    checkOutput("t4_stall_after_swap", wr_stall_o, 0);
    model_front = 1'b1;
    @(posedge clk); #1;
    checkOutput("t4_swap_pulse_end", swap_done_o, 0);
    applyStimulus(1, 0, 4'hA, 16'h0044, 16'h4444, 1);
    @(posedge clk); #1;
    checkOutput("t4_new_bank_msb", mem_addr_o[16], 0);
    waitDrain("t4_drain", 30);

    // Coinciding write+swap, then a second swap while pending
    ack_enable = 1'b0;
    pop_mark = pops_total;
    applyStimulus(1, 0, 4'h7, 16'h0050, 16'h5050, 1);
    applyStimulus(1, 1, 4'h8, 16'h0051, 16'h5151, 1);
    applyStimulus(0, 1, 4'h0, 16'h0, 16'h0, 0);
    ack_enable = 1'b1;
    pulses = 0; pop_delta = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (swap_done_o) begin
        pulses++;
        pop_delta = pops_total - pop_mark;
      end
    end
    checkOutput("t5_one_flip", pulses, 1);
    checkOutput("t5_writes_before_flip", pop_delta, 2);
    checkOutput("t5_front", front_buf_o, 0);
    model_front = 1'b0;
    waitDrain("t5_drain", 20);
`ifdef VRAM_WB_STATS_EN
    checkOutput("stats_count", write_count_o, 16'd24);
`endif

    // Reset mid-BUSY
    ack_enable = 1'b0;
    applyStimulus(1, 0, 4'h6, 16'h0060, 16'h6060, 1);
    @(posedge clk); #1;
    checkOutput("t6_busy", mem_sel_o, 1);
    @(negedge clk); #2;
    reset_n_i = 1'b0;
    #1;
    checkOutput("t6_async_sel", mem_sel_o, 0);
    checkOutput("t6_overflow_cleared", overflow_o, 0);
    exp_q.delete();
    @(negedge clk); reset_n_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_fifo_empty", mem_sel_o, 0);
    checkOutput("t6_stall", wr_stall_o, 0);
`ifdef VRAM_WB_STATS_EN
    checkOutput("t6_stats_reset", write_count_o, 0);
`endif
    ack_enable = 1'b1;
    applyStimulus(1, 0, 4'h2, 16'h0070, 16'h7070, 1);
    waitDrain("t6_drain", 20);

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_write_buffer.md
Name: vram_write_buffer

Overview:
- Sits directly downstream of the graphite rasterizer VRAM write port and decouples it from a VRAM controller that acknowledges each access.
- Queues pixel writes in a FIFO and issues them one at a time over a sel/ack handshake.
- Each write is tagged with the current back-buffer bank.
- Defers a swap request until every queued write has retired, then flips the front buffer.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 16, pixel address width from rasterizer.
- DATA_W, 16, pixel data width.

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- wr_sel_i  in  1  rasterizer VRAM select
- wr_en_i  in  1  rasterizer write enable; only sel&en cycles are writes
- wr_mask_i  in  4  write mask
- wr_addr_i  in  ADDR_W  pixel address
- wr_data_i  in  DATA_W  pixel data
- swap_req_i  in  1  single-cycle swap request from rasterizer
- wr_stall_o  out  1  backpressure: writes not accepted this cycle
- mem_sel_o  out  1  VRAM transaction request
- mem_wr_o  out  1  always equals mem_sel_o (write-only block)
- mem_mask_o  out  4  mask of head entry
- mem_addr_o  out  ADDR_W+1  {bank, addr}; MSB is the back-buffer bank
- mem_data_o  out  DATA_W  data of head entry
- mem_ack_i  in  1  controller accepted current transaction
- front_buf_o  out  1  bank currently displayed
- swap_done_o  out  1  one-cycle pulse when the bank flips
- overflow_o  out  1  sticky: a write arrived while stalled

Behaviour:
- Reset (async, active-low): FIFO empty, count=0.
  - All outputs 0: mem_sel_o, mem_wr_o, swap_done_o, front_buf_o, overflow_o, swap_pending.
  - wr_stall_o=0; mem_mask/addr/data=0.
  - Any in-flight transaction is abandoned; mem_sel_o drops immediately.
- Enqueue: on a cycle with wr_sel_i&wr_en_i&!wr_stall_o, push {~front_buf_o, mask, addr, data}.
  - sel without en is ignored.
- wr_stall_o = (count==DEPTH) | swap_pending (combinational).
- Write while wr_stall_o=1: dropped; overflow_o set, cleared only by reset.
- Issue FSM states:
  - IDLE: if FIFO non-empty, register head fields onto mem_* outputs, set mem_sel_o=1, go to BUSY (1 cycle from push to mem_sel_o).
  - BUSY: mem_* held stable until mem_ack_i=1 sampled. On ack: pop, mem_sel_o=0 next cycle, go to IDLE.
  - Minimum one low cycle between transactions; peak throughput 1 write per 2 cycles.
  - mem_ack_i in IDLE is ignored.
- Simultaneous push and pop in the same cycle: count unchanged; a full FIFO stays full for that cycle (stall computed from registered count).
- FIFO pointers are log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
- Swap handling:
  - swap_req_i sets swap_pending.
  - A write and a swap_req in the same cycle: the write is accepted first, then pending is set.
  - swap_req while already pending: merged, no second flip.
  - Flip condition: swap_pending & FIFO empty & state IDLE. Then front_buf_o toggles, swap_done_o pulses for exactly 1 cycle, and swap_pending clears the same cycle.
  - Writes resume (stall releases) the following cycle, tagged with the new back bank.

Optional Feature:
- VRAM_WB_STATS_EN defined:
  - Adds port write_count_o, out, 16 bits.
  - Increments on every acknowledged transaction and wraps at 16'hFFFF->0.
  - Resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single write (mask 4'hF, addr 16'h0010, data 16'hABCD), ack held high → mem_sel_o rises 1 cycle after the push, mem_addr_o=17'h10010, mem_data_o=16'hABCD; sel low the cycle after ack.
- Push 16 writes with ack held low → wr_stall_o=1 after the 16th; a 17th write sets overflow_o=1. Releasing ack drains the entries in order, addr 0..15.
- Controller delays ack 5 cycles → mem_mask/addr/data remain stable for all 6 sel cycles; exactly one pop.
- 3 queued writes, then swap_req_i → wr_stall_o=1 until the third ack, then swap_done_o pulses once and front_buf_o=1. The next write is issued with mem_addr_o MSB=0.
- Second swap_req while pending, plus a write coinciding with the first swap_req → one flip only; the coinciding write is issued before the flip with the old bank.
- Assert reset_n_i low mid-BUSY → mem_sel_o=0 asynchronously and the FIFO is empty after release; with VRAM_WB_STATS_EN, write_count_o=0.
